// File: rtl/regbank_pkg.sv
// Shared definitions for the 8085 register bank: pair-op encodings,
// sweep state machine states and width helpers.
package regbank_pkg;

  typedef enum logic [1:0] {
    PR_NONE = 2'b00,
    PR_WR   = 2'b01,
    PR_INC  = 2'b10,
    PR_DEC  = 2'b11
  } pr_op_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  // Byte address width; a two-entry bank still needs one address bit
  function automatic int addr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Pair address width; never narrower than one bit
  function automatic int pair_width(input int aw);
    return (aw > 1) ? aw - 1 : 1;
  endfunction

endpackage

// File: rtl/regbank_pair_alu.sv
// Combinational 16-bit (2*DATA_W) increment/decrement unit for register pairs.
module regbank_pair_alu
  import regbank_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  pr_op_e              i_op,
  input  logic [2*DATA_W-1:0] i_pair,
  output logic [2*DATA_W-1:0] o_pair
);

  // Wrap-around inc/dec; any other op passes the pair through unchanged
  always_comb begin
    o_pair = i_pair;
    case (i_op)
      PR_INC:  o_pair = i_pair + (2*DATA_W)'(1);
      PR_DEC:  o_pair = i_pair - (2*DATA_W)'(1);
      default: o_pair = i_pair;
    endcase
  end

endmodule

// File: rtl/regbank_multi.sv
// Multi-port register bank with byte write port, register-pair port and a
// post-reset clear sweep. Storage has no per-entry reset; the sweep zeroes it.
// Optional macro REGBANK_BYPASS_EN forwards same-cycle byte/pair write data to
// the read ports; without it reads always show stored contents.
module regbank_multi
  import regbank_pkg::*;
#(
  parameter  int DATA_W   = 8,
  parameter  int NUM_REGS = 8,
  parameter  int NUM_RD   = 2,
  localparam int ADDR_W   = addr_width(NUM_REGS),
  localparam int PAIR_W   = pair_width(ADDR_W)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]   i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   o_rd_data,
  input  logic                       i_wr_en,
  input  logic [ADDR_W-1:0]          i_wr_addr,
  input  logic [DATA_W-1:0]          i_wr_data,
  input  logic [1:0]                 i_pr_op,
  input  logic [PAIR_W-1:0]          i_pr_addr,
  input  logic [2*DATA_W-1:0]        i_pr_wdata,
  output logic [2*DATA_W-1:0]        o_pr_data,
  output logic                       o_busy,
  output logic [DATA_W-1:0]          o_dbg0,
  output logic [DATA_W-1:0]          o_dbg1
);

  localparam logic [ADDR_W:0]   L_NUM_REGS = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] L_LAST     = ADDR_W'(NUM_REGS - 1);

  state_e              r_state;
  state_e              w_stateNext;
  logic [ADDR_W-1:0]   r_clrPtr;
  logic [ADDR_W-1:0]   w_clrPtrNext;
  logic                w_busy;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];

  pr_op_e              w_prOp;
  logic [ADDR_W-1:0]   w_pairHi;
  logic [ADDR_W-1:0]   w_pairLo;
  logic                w_pairInRange;
  logic                w_wrInRange;
  logic                w_byteWe;
  logic                w_pairWe;
  logic [2*DATA_W-1:0] w_pairStored;
  logic [2*DATA_W-1:0] w_pairAlu;
  logic [2*DATA_W-1:0] w_pairNew;

  assign w_prOp        = pr_op_e'(i_pr_op);
  assign w_pairHi      = ADDR_W'({i_pr_addr, 1'b0});
  assign w_pairLo      = w_pairHi | ADDR_W'(1);
  assign w_pairInRange = ({1'b0, w_pairLo} < L_NUM_REGS);
  assign w_wrInRange   = ({1'b0, i_wr_addr} < L_NUM_REGS);
  assign w_byteWe      = !w_busy && i_wr_en && w_wrInRange;
  assign w_pairWe      = !w_busy && (w_prOp != PR_NONE) && w_pairInRange;
  assign w_pairStored  = {r_regs[w_pairHi], r_regs[w_pairLo]};
  assign w_pairNew     = (w_prOp == PR_WR) ? i_pr_wdata : w_pairAlu;

`ifdef REGBANK_BYPASS_EN
  logic w_pairWr;
  logic w_byteFwd;
  assign w_pairWr  = w_pairWe && (w_prOp == PR_WR);
  assign w_byteFwd = w_byteWe && !(w_pairWe && (i_wr_addr == w_pairHi || i_wr_addr == w_pairLo));
`endif

  regbank_pair_alu #(.DATA_W(DATA_W)) u_pairAlu (
    .i_op   (w_prOp),
    .i_pair (w_pairStored),
    .o_pair (w_pairAlu)
  );

  // Sweep state register; reset restarts the sweep from entry 0
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= ST_CLEAR;
      r_clrPtr <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_clrPtr <= w_clrPtrNext;
    end
  end

  // Sweep next-state: walk every entry once, then go idle and drop busy
  always_comb begin
    w_stateNext  = r_state;
    w_clrPtrNext = r_clrPtr;
    w_busy       = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_busy       = 1'b1;
        w_clrPtrNext = r_clrPtr + ADDR_W'(1);
        if (r_clrPtr == L_LAST) begin
          w_stateNext  = ST_IDLE;
          w_clrPtrNext = '0;
        end
      end
      default: w_stateNext = r_state;
    endcase
  end

  // Storage writes; the pair update comes last so it wins a byte collision
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      if (w_busy) begin
        r_regs[r_clrPtr] <= '0;
      end else begin
        if (w_byteWe)
          r_regs[i_wr_addr] <= i_wr_data;
        if (w_pairWe) begin
          r_regs[w_pairHi] <= w_pairNew[2*DATA_W-1:DATA_W];
          r_regs[w_pairLo] <= w_pairNew[DATA_W-1:0];
        end
      end
    end
  end

  // One byte view shared by the read ports and the pair read port
  function automatic logic [DATA_W-1:0] f_readByte(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    if (!w_busy && ({1'b0, a} < L_NUM_REGS)) begin
      v = r_regs[a];
`ifdef REGBANK_BYPASS_EN
      if (w_pairWr && a == w_pairHi)
        v = i_pr_wdata[2*DATA_W-1:DATA_W];
      else if (w_pairWr && a == w_pairLo)
        v = i_pr_wdata[DATA_W-1:0];
      else if (w_byteFwd && a == i_wr_addr)
        v = i_wr_data;
`endif
    end
    return v;
  endfunction

  // Asynchronous byte read ports
  always_comb begin
    o_rd_data = '0;
    for (int k = 0; k < NUM_RD; k++)
      o_rd_data[k*DATA_W +: DATA_W] = f_readByte(i_rd_addr[k*ADDR_W +: ADDR_W]);
  end

  // Asynchronous pair read; inc/dec results only appear after the edge
  always_comb begin
    o_pr_data = '0;
    if (w_pairInRange)
      o_pr_data = {f_readByte(w_pairHi), f_readByte(w_pairLo)};
  end

  assign o_busy = w_busy;
  assign o_dbg0 = w_busy ? '0 : r_regs[0];
  assign o_dbg1 = w_busy ? '0 : r_regs[1];

endmodule
